// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer: borrows the shared combinational ALU
// while Busy and walks ADD/SHL/SHR until the multiplier shifts out to zero.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluOp,
  output logic             AluSC,
  input  logic [WIDTH-1:0] AluOut,
  input  logic             AluZero
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_SHL  = 3'd2;
  localparam logic [2:0] S_SHR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LSH = 3'b001;
  localparam logic [2:0] OP_RSH = 3'b010;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Each working state captures the ALU result into the register it drove.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d  = OpA;
          mplier_d = OpB;
          acc_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = AluOut;
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = AluOut;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = AluOut;
        state_d  = AluZero ? S_DONE : S_ADD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive decodes registered state only, so Start never reaches the ALU.
  always_comb begin
    AluOp = OP_ADD;
    AluA  = '0;
    AluB  = '0;
    case (state_q)
      S_ADD: begin
        AluOp = OP_ADD;
        AluA  = acc_q;
        AluB  = mplier_q[0] ? mcand_q : '0;
      end
      S_SHL: begin
        AluOp = OP_LSH;
        AluA  = mcand_q;
      end
      S_SHR: begin
        AluOp = OP_RSH;
        AluA  = mplier_q;
      end
      default: ;
    endcase
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = (state_q == S_DONE);
  assign Product = acc_q;
  assign AluSC   = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: reference ALU, cycle-level arithmetic model with a
// per-cycle compare, plus directed cases with hand-computed results.
module tb_alu_mul_seq;
  localparam int W = 8;

  logic         Clk, Reset_n, Start;
  logic [W-1:0] OpA, OpB, Product, AluA, AluB, AluOut;
  logic         Busy, Done, AluSC, AluZero;
  logic [2:0]   AluOp;

  int n_chk  = 0;
  int n_fail = 0;

  alu_mul_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Product(Product),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluSC(AluSC),
    .AluOut(AluOut), .AluZero(AluZero)
  );

  // Reference ALU
  always_comb begin
    case (AluOp)
      3'b000:  AluOut = AluA + AluB;
      3'b001:  AluOut = AluA << 1;
      3'b010:  AluOut = AluA >> 1;
      default: AluOut = '0;
    endcase
  end
  assign AluZero = (AluOut == '0);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned kof(input int unsigned b);
    int unsigned k = 1;
    for (int j = 0; j < W; j++) if (b[j]) k = j + 1;
    return k;
  endfunction

  // a times the low n bits of b, mod 2^W
  function automatic int unsigned pprod(input int unsigned a, input int unsigned b, input int unsigned n);
    return (a * (b & ((32'd1 << n) - 1))) & ((1 << W) - 1);
  endfunction

  // Model: cycle index c counts from 1 after the accept edge; done at 3k+1.
  bit          m_busy = 0;
  int unsigned m_a, m_b, m_k, m_c;
  int unsigned m_last = 0;
  bit          prev_add = 0;
  int unsigned prev_alu = 0;

  always @(posedge Clk) begin
    int unsigned ph, i, na, ea, eb, eo, ep;
    bit          ed;
    if (!Reset_n) begin
      m_busy = 0;
      m_last = 0;
      prev_add = 0;
    end else if (m_busy) begin
      m_c++;
      if (m_c > 3 * m_k + 1) begin
        m_busy = 0;
        m_last = pprod(m_a, m_b, W);
      end
    end else if (Start) begin
      m_busy = 1;
      m_a = OpA;
      m_b = OpB;
      m_k = kof(OpB);
      m_c = 1;
    end
    #2;
    ea = 0; eb = 0; eo = 0; ed = 0; ep = m_last;
    if (m_busy) begin
      if (m_c == 3 * m_k + 1) begin
        ed = 1;
        ep = pprod(m_a, m_b, W);
      end else begin
        ph = (m_c - 1) % 3;
        i  = (m_c - 1) / 3 + 1;
        na = (m_c + 1) / 3;
        ep = pprod(m_a, m_b, na);
        eo = ph;
        case (ph)
          0: begin
            ea = pprod(m_a, m_b, i - 1);
            eb = m_b[i-1] ? ((m_a << (i - 1)) & 8'hFF) : 0;
          end
          1: ea = (m_a << (i - 1)) & 8'hFF;
          default: ea = m_b >> (i - 1);
        endcase
      end
    end
    if (Reset_n) begin
      check("busy", Busy, m_busy);
      check("done", Done, ed);
      check("product", Product, ep);
      check("alu_a", AluA, ea);
      check("alu_b", AluB, eb);
      check("alu_op", AluOp, eo);
      check("alu_sc", AluSC, 0);
      if (prev_add) check("acc_capture", Product, prev_alu);
      prev_add = m_busy && (m_c != 3 * m_k + 1) && ((m_c - 1) % 3 == 0);
      prev_alu = AluOut;
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge Clk);
    while (Busy && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (Busy) check("idle_timeout", 1, 0);
  endtask

  // Launch one op; optionally poke Start with 1*1 during cycle 3.
  task automatic run_op(input string name, input int unsigned a, input int unsigned b,
                        input int unsigned exp_p, input int unsigned exp_cyc, input bit intr);
    int n = 0;
    int ndone = 0;
    bit got = 0;
    wait_idle();
    OpA = a[W-1:0]; OpB = b[W-1:0]; Start = 1'b1;
    @(posedge Clk); #2;
    Start = 1'b0;
    while (!got && n < 40) begin
      @(posedge Clk); #2;
      n++;
      if (intr && n == 2) begin Start = 1'b1; OpA = 8'd1; OpB = 8'd1; end
      if (intr && n == 3) Start = 1'b0;
      if (Done) begin got = 1; ndone++; end
    end
    Start = 1'b0;
    check({name, "_done_seen"}, got, 1);
    check({name, "_cycle"}, n + 1, exp_cyc);
    check({name, "_product"}, Product, exp_p);
    repeat (3) begin
      @(posedge Clk); #2;
      if (Done) ndone++;
    end
    check({name, "_one_done"}, ndone, 1);
    check({name, "_product_hold"}, Product, exp_p);
  endtask

  initial begin
    int seen, idle_between, t;
    int unsigned p1, p2;
    Reset_n = 1'b1; Start = 1'b0; OpA = '0; OpB = '0;
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_product", Product, 0);
    check("rst_alu", {AluA, AluB, AluOp, AluSC}, 0);
    Reset_n = 1'b1;

    run_op("mul3x5", 3, 5, 15, 10, 0);
    run_op("mul9x0", 9, 0, 0, 4, 0);
    run_op("mul0x9", 0, 9, 0, 13, 0);
    run_op("mul255x255", 255, 255, 1, 25, 0);
    run_op("mul16x16", 16, 16, 0, 16, 0);
    run_op("busy_start", 7, 6, 42, 10, 1);

    // Idle ALU drive
    @(negedge Clk);
    check("idle_alu_a", AluA, 0);
    check("idle_alu_b", AluB, 0);
    check("idle_alu_op", AluOp, 0);
    check("idle_alu_sc", AluSC, 0);

    // Back-to-back with Start held high
    wait_idle();
    OpA = 8'd2; OpB = 8'd3; Start = 1'b1;
    seen = 0; idle_between = 0; t = 0; p1 = 0; p2 = 0;
    while (seen < 2 && t < 60) begin
      @(posedge Clk); #2;
      t++;
      if (seen == 1 && !Busy) idle_between++;
      if (Done) begin
        if (seen == 0) p1 = Product; else p2 = Product;
        seen++;
      end
    end
    Start = 1'b0;
    check("b2b_count", seen, 2);
    check("b2b_p1", p1, 6);
    check("b2b_p2", p2, 6);
    check("b2b_idle_gap", idle_between, 1);

    // Reset mid-run aborts immediately
    wait_idle();
    OpA = 8'd100; OpB = 8'd200; Start = 1'b1;
    @(posedge Clk); #2 Start = 1'b0;
    repeat (4) @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_product", Product, 0);
    check("mid_rst_alu", {AluA, AluB, AluOp, AluSC}, 0);
    seen = 0;
    repeat (3) begin
      @(posedge Clk); #2;
      if (Done) seen++;
    end
    @(negedge Clk) Reset_n = 1'b1;
    repeat (30) begin
      @(posedge Clk); #2;
      if (Done) seen++;
    end
    check("mid_rst_no_done", seen, 0);

    // Randomized traffic, checked by the per-cycle model
    for (int r = 0; r < 1500; r++) begin
      @(negedge Clk);
      Start = ($urandom_range(0, 3) == 0);
      OpA = W'($urandom);
      case ($urandom_range(0, 3))
        0: OpB = W'($urandom);
        1: OpB = '0;
        2: OpB = W'(1 << $urandom_range(0, W - 1));
        default: OpB = W'($urandom_range(0, 7));
      endcase
    end
    Start = 1'b0;
    repeat (30) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
